// File: rtl/seq_divider_4b.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// WIDTH iterations per division, one-cycle done pulse with registered results.
module seq_divider_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    // The partial remainder is always < divisor after restore, so WIDTH bits
    // hold it; the extra bit only exists in the trial result as the borrow.
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        shifted  = {rem_r, q_r[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_r};
        q_ext    = {q_r, ~trial[WIDTH]};
        q_next   = q_ext[WIDTH-1:0];
        rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_r       <= '0;
            q_r         <= '0;
            dvs_r       <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor != '0) begin
                            dvs_r       <= divisor;
                            q_r         <= dividend;
                            rem_r       <= '0;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end else begin
                            // Divide-by-zero skips iteration entirely.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_next;
                    q_r   <= q_next;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        quotient  <= q_next;
                        remainder <= rem_next;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_4b.sv
// Scoreboard bench for seq_divider_4b: expected results are queued at each
// accepted start and compared whenever done pulses.
module tb_seq_divider_4b;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    seq_divider_4b #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = 4'hF; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Output monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", {28'd0, quotient}, {28'd0, e.q});
                chk("remainder", {28'd0, remainder}, {28'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input bit push);
        start = 1'b1; dividend = a; divisor = b;
        if (push) sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {28'd0, quotient}, 32'd0);
        chk("rst_r", {28'd0, remainder}, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);

        // 1: 13/3 with cycle-exact busy/done timing
        start_op(4'd13, 4'd3, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("t1_busy_%0d", i), {31'd0, busy}, {31'd0, (i <= 5)});
            chk($sformatf("t1_done_%0d", i), {31'd0, done}, {31'd0, (i == 5)});
            @(negedge clk);
        end
        wait_idle();

        // 2: boundaries
        start_op(4'd15, 4'd1, 1'b1); wait_idle();
        start_op(4'd5, 4'd7, 1'b1);  wait_idle();

        // 3: divide by zero, done right after accept, then cleared by next op
        start_op(4'd9, 4'd0, 1'b1);
        chk("t3_dz_done", {31'd0, done}, 32'd1);
        wait_idle();
        start_op(4'd6, 4'd2, 1'b1); wait_idle();
        chk("t3_dz_clear", {31'd0, div_by_zero}, 32'd0);

        // 4: start pulses during CALC and DONE are ignored, held start is accepted after IDLE
        base = done_cnt;
        start_op(4'd13, 4'd3, 1'b1);          // now at N1
        @(negedge clk);                        // N2: second CALC cycle
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(negedge clk);                        // N3
        start = 1'b0;
        @(negedge clk);                        // N4
        @(negedge clk);                        // N5: DONE
        chk("t4_done_cycle", {31'd0, done}, 32'd1);
        start = 1'b1;
        @(negedge clk);                        // N6: IDLE, start still held
        chk("t4_one_done", done_cnt - base, 32'd1);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        sb.push_back(model(4'd6, 4'd2));
        @(negedge clk);                        // N7
        start = 1'b0;
        chk("t4_accepted", {31'd0, busy}, 32'd1);
        chk("t4_q_hold", {28'd0, quotient}, 32'd4);
        wait_idle();

        // 5: reset abort in third CALC cycle
        base = done_cnt;
        start_op(4'd12, 4'd5, 1'b0);           // N1
        @(negedge clk);                        // N2
        @(negedge clk);                        // N3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_q", {28'd0, quotient}, 32'd0);
        chk("t5_r", {28'd0, remainder}, 32'd0);
        repeat (6) @(negedge clk);
        chk("t5_no_done", done_cnt - base, 32'd0);
        start_op(4'd8, 4'd2, 1'b1); wait_idle();

        // 6: exhaustive sweep
        base = done_cnt;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(4'(a), 4'(b), 1'b1);
                wait_idle();
            end
        end
        chk("t6_done_count", done_cnt - base, 32'd256);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
